// File: rtl/gcd_if.sv
// Operand and result handshake bundle for the GCD engine.
// master = operand source / result consumer, slave = engine.
interface gcd_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic [CNT_W-1:0] iters;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, iters, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, iters, busy
  );
endinterface

// File: rtl/gcd_engine.sv
// Iterative GCD engine: subtractive Euclid (ALGO=0) or binary Stein (ALGO=1),
// one step per cycle, with saturating iteration count.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | one reduction step per cycle until A==B
// DONE  | result held with out_valid until out_ready
//
// A zero-operand capture goes straight to DONE but raises out_valid one
// cycle later, so every result appears (iters+1) cycles after capture.
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int ALGO  = 0,
  parameter int CNT_W = 16
) (
  input logic  clk,
  input logic  rst_n,
  gcd_if.slave bus
);

  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] gcd_r;
  logic [CNT_W-1:0] iters_r;
  logic [CNT_W-1:0] iters_inc;
  logic [K_W-1:0]   k_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  assign iters_inc = (&iters_r) ? iters_r : iters_r + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      gcd_r       <= '0;
      iters_r     <= '0;
      k_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a_in;
            b_r        <= bus.b_in;
            iters_r    <= '0;
            k_r        <= '0;
            in_ready_r <= 1'b0;
            if (bus.a_in == '0 || bus.b_in == '0) begin
              gcd_r <= bus.a_in | bus.b_in;
              state <= DONE;
            end else begin
              busy_r <= 1'b1;
              state  <= CALC;
            end
          end
        end

        CALC: begin
          if (a_r == b_r) begin
            gcd_r       <= (ALGO == 0) ? a_r : (a_r << k_r);
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            iters_r <= iters_inc;
            if (ALGO == 0) begin
              if (a_r > b_r) a_r <= a_r - b_r;
              else           b_r <= b_r - a_r;
            end else begin
              // Stein: strip common factors of two first, then odd-side shifts
              if (!a_r[0] && !b_r[0]) begin
                a_r <= a_r >> 1;
                b_r <= b_r >> 1;
                k_r <= k_r + 1'b1;
              end else if (!a_r[0]) begin
                a_r <= a_r >> 1;
              end else if (!b_r[0]) begin
                b_r <= b_r >> 1;
              end else if (a_r > b_r) begin
                a_r <= a_r - b_r;
              end else begin
                b_r <= b_r - a_r;
              end
            end
          end
        end

        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.gcd_out   = gcd_r;
  assign bus.iters     = iters_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: five instances (16-bit Euclid/Stein,
// 8-bit Euclid/Stein, 8-bit Euclid with 4-bit counter) driven in two groups.
module tb_gcd_engine;

  typedef struct {
    logic [15:0] g;
    logic [15:0] it;
    int          lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        s16_v = 1'b0, s16_or = 1'b1;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic        s8_v = 1'b0, s8_or = 1'b1;
  logic [7:0]  s8_a = '0, s8_b = '0;

  gcd_if #(.WIDTH(16), .CNT_W(16)) if0 ();
  gcd_if #(.WIDTH(16), .CNT_W(16)) if1 ();
  gcd_if #(.WIDTH(8),  .CNT_W(16)) if2 ();
  gcd_if #(.WIDTH(8),  .CNT_W(16)) if3 ();
  gcd_if #(.WIDTH(8),  .CNT_W(4))  if4 ();

  gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gcd_engine #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  gcd_engine #(.WIDTH(8),  .ALGO(0), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  gcd_engine #(.WIDTH(8),  .ALGO(1), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  gcd_engine #(.WIDTH(8),  .ALGO(0), .CNT_W(4))  u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  assign if0.in_valid = s16_v;  assign if0.a_in = s16_a;  assign if0.b_in = s16_b;  assign if0.out_ready = s16_or;
  assign if1.in_valid = s16_v;  assign if1.a_in = s16_a;  assign if1.b_in = s16_b;  assign if1.out_ready = s16_or;
  assign if2.in_valid = s8_v;   assign if2.a_in = s8_a;   assign if2.b_in = s8_b;   assign if2.out_ready = s8_or;
  assign if3.in_valid = s8_v;   assign if3.a_in = s8_a;   assign if3.b_in = s8_b;   assign if3.out_ready = s8_or;
  assign if4.in_valid = s8_v;   assign if4.a_in = s8_a;   assign if4.b_in = s8_b;   assign if4.out_ready = s8_or;

  // Flattened views so one monitor loop covers every instance
  logic        ov [5];
  logic        ir [5];
  logic        iv [5];
  logic [15:0] g  [5];
  logic [15:0] it [5];

  assign ov[0] = if0.out_valid; assign ir[0] = if0.in_ready; assign iv[0] = if0.in_valid;
  assign ov[1] = if1.out_valid; assign ir[1] = if1.in_ready; assign iv[1] = if1.in_valid;
  assign ov[2] = if2.out_valid; assign ir[2] = if2.in_ready; assign iv[2] = if2.in_valid;
  assign ov[3] = if3.out_valid; assign ir[3] = if3.in_ready; assign iv[3] = if3.in_valid;
  assign ov[4] = if4.out_valid; assign ir[4] = if4.in_ready; assign iv[4] = if4.in_valid;
  assign g[0] = if0.gcd_out;          assign it[0] = if0.iters;
  assign g[1] = if1.gcd_out;          assign it[1] = if1.iters;
  assign g[2] = {8'h00, if2.gcd_out}; assign it[2] = if2.iters;
  assign g[3] = {8'h00, if3.gcd_out}; assign it[3] = if3.iters;
  assign g[4] = {8'h00, if4.gcd_out}; assign it[4] = {12'h000, if4.iters};

  sb_t q [5][$];
  int  lat  [5];
  bit  pend [5];
  bit  hold [5];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u%0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic sb_t mk(input int gv, input int itv, input int latv);
    sb_t e;
    e.g   = 16'(gv);
    e.it  = 16'(itv);
    e.lat = latv;
    return e;
  endfunction

  // Monitor: tracks captures and compares each first out_valid against the queue
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0;
        hold[i] = 1'b0;
      end else if (pend[i]) begin
        lat[i]++;
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            fails++;
            $display("FAIL result u%0d: got gcd %0d, expected no result", i, g[i]);
          end else begin
            sb_t e;
            e = q[i].pop_front();
            check("gcd", i, 32'(g[i]), 32'(e.g));
            check("iters", i, 32'(it[i]), 32'(e.it));
            check("latency", i, lat[i], e.lat);
          end
          pend[i] = 1'b0;
          hold[i] = 1'b1;
        end else if (lat[i] >= 0) begin
          check("in_ready_busy", i, 32'(ir[i]), 32'd0);
        end
      end else begin
        if (ov[i] && !hold[i]) begin
          fails++;
          $display("FAIL spurious_out_valid u%0d: got 1, expected 0", i);
        end
        if (!ov[i]) hold[i] = 1'b0;
        if (iv[i] && ir[i]) begin
          pend[i] = 1'b1;
          lat[i]  = -1;
        end
      end
    end
  end

  task automatic cap16(input logic [15:0] a, input logic [15:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    s16_a = a; s16_b = b; s16_v = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (if0.in_ready && if1.in_ready) ok = 1'b1;
    end
    if (!ok) begin fails++; $display("FAIL cap16_timeout: got no in_ready, expected in_ready"); end
    @(posedge clk); #1;
    s16_v = 1'b0;
  endtask

  task automatic cap8(input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    s8_a = a; s8_b = b; s8_v = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (if2.in_ready && if3.in_ready && if4.in_ready) ok = 1'b1;
    end
    if (!ok) begin fails++; $display("FAIL cap8_timeout: got no in_ready, expected in_ready"); end
    @(posedge clk); #1;
    s8_v = 1'b0;
  endtask

  task automatic wait16();
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (q[0].size() == 0 && q[1].size() == 0 && if0.in_ready && if1.in_ready) ok = 1'b1;
    end
    if (!ok) begin fails++; $display("FAIL wait16_timeout: got pending results, expected idle"); end
  endtask

  task automatic wait8();
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (q[2].size() == 0 && q[3].size() == 0 && q[4].size() == 0 &&
          if2.in_ready && if3.in_ready && if4.in_ready) ok = 1'b1;
    end
    if (!ok) begin fails++; $display("FAIL wait8_timeout: got pending results, expected idle"); end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input int g0, input int it0, input int g1, input int it1);
    q[0].push_back(mk(g0, it0, it0 + 1));
    q[1].push_back(mk(g1, it1, it1 + 1));
    cap16(a, b);
    wait16();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 0, 32'(if0.in_ready), 32'd1);
    check("rst_out_valid", 0, 32'(if0.out_valid), 32'd0);
    check("rst_busy", 0, 32'(if0.busy), 32'd0);
    check("rst_gcd", 0, 32'(if0.gcd_out), 32'd0);
    check("rst_iters", 0, 32'(if0.iters), 32'd0);
    check("rst_iters", 4, 32'(if4.iters), 32'd0);
    #2 rst_n = 1'b1;

    run16(16'd143, 16'd78,  13, 6, 13, 7);
    run16(16'd48,  16'd180, 12, 6, 12, 10);
    run16(16'd0,   16'd25,  25, 0, 25, 0);
    run16(16'd25,  16'd0,   25, 0, 25, 0);
    run16(16'd0,   16'd0,   0,  0, 0,  0);

    // Backpressure: hold result, pulse an ignored operand pair
    s16_or = 1'b0;
    q[0].push_back(mk(13, 6, 7));
    q[1].push_back(mk(13, 7, 8));
    cap16(16'd143, 16'd78);
    begin
      bit ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (if0.out_valid && if1.out_valid) ok = 1'b1;
      end
      if (!ok) begin fails++; $display("FAIL bp_timeout: got no out_valid, expected out_valid"); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      s16_a = 16'd9; s16_b = 16'd6; s16_v = (c == 2);
      @(negedge clk);
      check("bp_out_valid", 0, 32'(if0.out_valid), 32'd1);
      check("bp_in_ready", 0, 32'(if0.in_ready), 32'd0);
      check("bp_gcd", 0, 32'(if0.gcd_out), 32'd13);
      check("bp_gcd", 1, 32'(if1.gcd_out), 32'd13);
      check("bp_iters", 1, 32'(if1.iters), 32'd7);
      check("bp_busy", 0, 32'(if0.busy), 32'd0);
    end
    s16_v = 1'b0;
    s16_or = 1'b1;
    wait16();
    run16(16'd9, 16'd6, 3, 2, 3, 3);

    // Asynchronous reset three cycles into CALC
    cap16(16'd1000, 16'd1);
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy", 0, 32'(if0.busy), 32'd1);
    check("mid_busy", 1, 32'(if1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 0, 32'(if0.in_ready), 32'd1);
    check("abort_out_valid", 0, 32'(if0.out_valid), 32'd0);
    check("abort_busy", 0, 32'(if0.busy), 32'd0);
    check("abort_iters", 0, 32'(if0.iters), 32'd0);
    check("abort_gcd", 0, 32'(if0.gcd_out), 32'd0);
    check("abort_busy", 1, 32'(if1.busy), 32'd0);
    check("abort_out_valid", 1, 32'(if1.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run16(16'd21, 16'd14, 7, 2, 7, 3);

    // 8-bit extremes, including counter saturation on the 4-bit instance
    q[2].push_back(mk(1, 254, 255));
    q[3].push_back(mk(1, 14, 15));
    q[4].push_back(mk(1, 15, 255));
    cap8(8'd255, 8'd1);
    wait8();
    q[2].push_back(mk(255, 0, 1));
    q[3].push_back(mk(255, 0, 1));
    q[4].push_back(mk(255, 0, 1));
    cap8(8'd255, 8'd255);
    wait8();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
